// File: rtl/frame_param_bank_if.sv
// Avalon-MM slave bus bundle for the frame parameter bank.
// master drives commands; slave returns registered read data.
interface frame_param_bank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avs_address;
  logic                avs_write;
  logic [DATA_W-1:0]   avs_writedata;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic                avs_read;
  logic [DATA_W-1:0]   avs_readdata;
  logic                avs_readdatavalid;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_byteenable,
    output avs_read,
    input  avs_readdata,
    input  avs_readdatavalid
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_byteenable,
    input  avs_read,
    output avs_readdata,
    output avs_readdatavalid
  );
endinterface

// File: rtl/frame_param_bank.sv
// Double-buffered shadow/active parameter bank for the raymarcher.
// Active words reload from shadow only on a committed frame boundary.
module frame_param_bank #(
  parameter int NUM_REGS = 20,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  frame_param_bank_if.slave          bus,
  input  logic                       frame_done,
  output logic [NUM_REGS*DATA_W-1:0] params_out,
  output logic                       params_updated,
  output logic                       commit_pending
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(NUM_REGS + 1);

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic              rdsel_q;
  logic              imm_q;
  logic              arm_q;
  logic [15:0]       frame_cnt_q;
  logic              upd_q;
  logic [DATA_W-1:0] rd_q;
  logic              rdv_q;

  logic              wr_shadow;
  logic              wr_ctrl;
  logic              arm_wr;
  logic              commit;
  logic              imm_wr;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] status_word;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  assign wr_shadow = bus.avs_write && (bus.avs_address < CTRL_A);
  assign wr_ctrl   = bus.avs_write && (bus.avs_address == CTRL_A);
  assign arm_wr    = wr_ctrl && bus.avs_writedata[0];
  // an arming write in the same cycle as frame_done commits at once
  assign commit    = frame_done && (arm_q || arm_wr);
  assign imm_wr    = wr_shadow && imm_q;

  assign status_word = DATA_W'({frame_cnt_q, 15'd0, arm_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_shadow && bus.avs_address == ADDR_W'(i))
          shadow_q[i] <= merge(shadow_q[i], bus.avs_writedata,
                               bus.avs_byteenable);
    end
  end

  // commit takes pre-write shadow; an immediate write overlays its bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        active_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (imm_wr && bus.avs_address == ADDR_W'(i))
          active_q[i] <= merge(commit ? shadow_q[i] : active_q[i],
                               bus.avs_writedata, bus.avs_byteenable);
        else if (commit)
          active_q[i] <= shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdsel_q <= 1'b0;
      imm_q   <= 1'b0;
    end else if (wr_ctrl) begin
      rdsel_q <= bus.avs_writedata[1];
      imm_q   <= bus.avs_writedata[2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q       <= 1'b0;
      frame_cnt_q <= '0;
      upd_q       <= 1'b0;
    end else begin
      if (commit)
        arm_q <= 1'b0;
      else if (arm_wr)
        arm_q <= 1'b1;
      if (commit)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      upd_q <= commit || imm_wr;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.avs_address == ADDR_W'(i))
        rd_word = rdsel_q ? active_q[i] : shadow_q[i];
    if (bus.avs_address == CTRL_A)
      rd_word = DATA_W'({imm_q, rdsel_q, 1'b0});
    if (bus.avs_address == STAT_A)
      rd_word = status_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      rdv_q <= 1'b0;
    end else begin
      rdv_q <= bus.avs_read;
      if (bus.avs_read)
        rd_q <= rd_word;
    end
  end

  assign bus.avs_readdata      = rd_q;
  assign bus.avs_readdatavalid = rdv_q;
  assign params_updated        = upd_q;
  assign commit_pending        = arm_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign params_out[g*DATA_W +: DATA_W] = active_q[g];
  end

endmodule

// File: doc/frame_param_bank.md
# frame_param_bank

Parametrised, double-buffered parameter register bank between the HPS lightweight bus and the raymarching pipeline. It generalises the fixed set of single-word camera, colour and fog PIO exports into NUM_REGS shadow/active register pairs. The shadow copies are written by the CPU at any time. The active copies drive the renderer and change only at a frame boundary, so every frame renders with one consistent camera and shading set.

## Interface

Parameters:
- NUM_REGS, 20: number of parameter words; must be between 1 and 62.
- DATA_W, 32: width of each parameter word, in bits; must be a multiple of 8.
- ADDR_W, 6: word-address width; requires 2^ADDR_W >= NUM_REGS+2.

Ports:
- clk  in  1  single clock (M10K/pipeline domain); also the bus clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  DATA_W  write data.
- avs_byteenable  in  DATA_W/8  byte lanes.
- avs_read  in  1  read strobe.
- avs_readdata  out  DATA_W  registered read data.
- avs_readdatavalid  out  1  high 1 cycle after an accepted read.
- frame_done  in  1  single-cycle pulse from the renderer marking the last pixel of a frame.
- params_out  out  NUM_REGS*DATA_W  active words, concatenated; word i is at [i*DATA_W +: DATA_W].
- params_updated  out  1  one-cycle pulse in the cycle after active is loaded.
- commit_pending  out  1  a commit is armed and waiting for frame_done.

## Operation

- Address map:
  - Addresses 0..NUM_REGS-1 are the shadow words.
  - Address NUM_REGS is CTRL.
  - Address NUM_REGS+1 is STATUS.
  - Any other address reads 0; writes to it are ignored.
- Shadow writes: merged per byte lane under avs_byteenable.
- CTRL fields:
  - Bit 0, COMMIT, write-1-to-arm. Sets the commit flag. Writing 0 does nothing; the bit reads 0.
  - Bit 1, RDSEL, R/W. 0 = shadow addresses read back the shadow word; 1 = they read back the active word.
  - Bit 2, IMMEDIATE, R/W. 1 = every shadow write also writes the same bytes into active in the same cycle, and params_updated pulses for that write.
  - Other bits read 0.
- STATUS fields (read-only; writes ignored):
  - Bit 0 = commit_pending.
  - Bits 31:16 = 16-bit count of committed frames. Increments on every commit and wraps from 0xFFFF to 0.
  - Other bits read 0.
- Commit: when frame_done is high and the commit flag is set:
  - all active words load from the shadow words;
  - the commit flag clears;
  - the frame count increments;
  - params_updated pulses in the next cycle.
- frame_done while the commit flag is clear has no effect.
- Simultaneous events:
  - Shadow write and commit in the same cycle: active takes the shadow value from before the write. The new value stays in shadow only, for the next commit.
  - COMMIT write and frame_done in the same cycle: the commit happens in that cycle, and commit_pending stays 0.
  - Read and write in the same cycle: the read returns the value from before the write.
- Reset values:
  - all shadow and active words = 0;
  - CTRL = 0;
  - commit flag = 0;
  - frame count = 0;
  - avs_readdata = 0;
  - avs_readdatavalid, params_updated and commit_pending = 0.
- Reset in the middle of an armed commit discards the commit.

## Timing

- No wait states. A write takes effect on the clock edge where avs_write is sampled.
- Read latency is exactly 1 cycle: avs_readdatavalid is high in the cycle after avs_read. Back-to-back reads are supported, one per cycle.
- params_out is registered. It changes only:
  - on the clock edge of a commit, or
  - on the edge of a write in IMMEDIATE mode.
- params_updated is high in the cycle after that edge, for 1 cycle only.
- commit_pending goes high in the cycle after the COMMIT write and low in the cycle after the commit edge.

## Test plan

- Reset values: hold reset, then release. params_out = 0, STATUS reads 0x0000_0000, avs_readdatavalid is 0 until the first read, and a read of address 3 returns 0 one cycle later.
- Commit flow:
  - write word 0 = 0x0001_0000 and word 5 = 0xDEAD_BEEF; params_out does not change;
  - write CTRL = 1; commit_pending = 1;
  - pulse frame_done; on that edge word 0 of params_out = 0x0001_0000, params_updated pulses once, and STATUS = 0x0001_0000.
- Same-cycle shadow write and commit:
  - arm a commit with shadow word 2 = 0x11;
  - in one cycle, write word 2 = 0x22 and pulse frame_done;
  - active word 2 = 0x11, shadow word 2 = 0x22;
  - after a second commit, active word 2 = 0x22.
- Byte enables and IMMEDIATE mode:
  - with CTRL = 4, write 0xAABB_CCDD to word 1 with byteenable 0b0101;
  - active and shadow word 1 both = 0x00BB_00DD, and params_updated pulses.
- Readback select and address range:
  - with RDSEL = 1, a shadow address returns the active word;
  - address NUM_REGS+2 returns 0;
  - a write to that address changes no state.
- Frame count wrap and reset while armed:
  - 65536 commits bring STATUS[31:16] back to 0;
  - arm a commit, assert reset, release, pulse frame_done: no commit occurs and params_out stays 0.
